// File: rtl/dcache_port_arbiter_pkg.sv
// rtl/dcache_port_arbiter_pkg.sv - shared command layout and slot ID encoding for the dcache port arbiter
package dcache_port_arbiter_pkg;

  // Command word layout: {wr, size, wstrb, addr, wdata}
  localparam int CMD_WD_DEFAULT = 71;
  localparam int CMD_WR_BIT     = 70;
  localparam int CMD_SIZE_MSB   = 69;
  localparam int CMD_SIZE_LSB   = 68;
  localparam int CMD_WSTRB_MSB  = 67;
  localparam int CMD_WSTRB_LSB  = 64;
  localparam int CMD_ADDR_MSB   = 63;
  localparam int CMD_ADDR_LSB   = 32;
  localparam int CMD_WDATA_MSB  = 31;
  localparam int CMD_WDATA_LSB  = 0;

  // Which issue slot owns an outstanding cache request
  typedef enum logic {
    SLOT_1 = 1'b0,
    SLOT_2 = 1'b1
  } slot_id_e;

endpackage

// File: rtl/dcache_port_arbiter_id_fifo.sv
// rtl/dcache_port_arbiter_id_fifo.sv - in-order FIFO of slot IDs for accepted, unanswered requests
module id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int PTR_WD = $clog2(DEPTH),
  localparam int CNT_WD = PTR_WD + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  head,
  output logic              full,
  output logic              empty,
  output logic [CNT_WD-1:0] count
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [PTR_WD-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WD-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WD-1:0] count_q, count_d;
  logic              push_en, pop_en;

  assign full  = (count_q == CNT_WD'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Pointer, count and storage update; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_en   = pop & ~empty;
    push_en  = push & (~full | pop_en);
    if (push_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless until written so no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - fixed-priority two-slot arbiter onto a single data cache port with in-order response routing
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CMD_WD = CMD_WD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p1_req,
  input  logic [CMD_WD-1:0] p1_cmd,
  output logic              p1_addr_ok,
  output logic              p1_data_ok,
  output logic [31:0]       p1_rdata,
  input  logic              p2_req,
  input  logic [CMD_WD-1:0] p2_cmd,
  output logic              p2_addr_ok,
  output logic              p2_data_ok,
  output logic [31:0]       p2_rdata,
  output logic              c_req,
  output logic [CMD_WD-1:0] c_cmd,
  input  logic              c_addr_ok,
  input  logic              c_data_ok,
  input  logic [31:0]       c_rdata
);

  localparam int CNT_WD = $clog2(DEPTH) + 1;

  logic              grant1, grant2;
  logic              accept, pop_valid;
  logic              fifo_full, fifo_empty;
  logic [0:0]        fifo_head;
  logic [0:0]        push_id;
  logic [CNT_WD-1:0] fifo_count;
  logic              err_q, err_d;

  // Grant and cache request: slot 1 always wins so the older instruction goes first
  always_comb begin
    grant1  = p1_req;
    grant2  = ~p1_req & p2_req;
    c_req   = (p1_req | p2_req) & ~fifo_full & ~reset;
    c_cmd   = '0;
    if (grant1) begin
      c_cmd = p1_cmd;
    end else if (grant2) begin
      c_cmd = p2_cmd;
    end
    accept     = c_req & c_addr_ok;
    p1_addr_ok = accept & grant1;
    p2_addr_ok = accept & grant2;
    push_id    = grant2 ? 1'(SLOT_2) : 1'(SLOT_1);
  end

  // Response routing: a data_ok with nothing outstanding belongs to nobody and is dropped
  always_comb begin
    pop_valid  = c_data_ok & ~fifo_empty & ~reset;
    p1_data_ok = pop_valid & (slot_id_e'(fifo_head) == SLOT_1);
    p2_data_ok = pop_valid & (slot_id_e'(fifo_head) == SLOT_2);
    p1_rdata   = p1_data_ok ? c_rdata : 32'h0;
    p2_rdata   = p2_data_ok ? c_rdata : 32'h0;
    err_d      = err_q | (c_data_ok & (fifo_count == '0) & ~accept);
  end

  // Sticky protocol error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (1)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_id),
    .pop       (pop_valid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - scoreboard bench for dcache_port_arbiter
module tb_dcache_port_arbiter;

  localparam int CMD_WD = 71;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              p1_req, p2_req;
  logic [CMD_WD-1:0] p1_cmd, p2_cmd;
  logic              p1_addr_ok, p1_data_ok, p2_addr_ok, p2_data_ok;
  logic [31:0]       p1_rdata, p2_rdata;
  logic              c_req, c_addr_ok, c_data_ok;
  logic [CMD_WD-1:0] c_cmd;
  logic [31:0]       c_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  int          exp_slot_q[$];
  logic [31:0] exp_data_q[$];

  localparam logic [CMD_WD-1:0] P1CMD = {1'b0, 2'b10, 4'hf, 32'h0000_1000, 32'h0000_0000};
  localparam logic [CMD_WD-1:0] P2CMD = {1'b1, 2'b10, 4'hf, 32'h0000_2004, 32'hdead_beef};

  always #5 clk = ~clk;

  dcache_port_arbiter #(.DEPTH(DEPTH), .CMD_WD(CMD_WD)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .p1_req     (p1_req),
    .p1_cmd     (p1_cmd),
    .p1_addr_ok (p1_addr_ok),
    .p1_data_ok (p1_data_ok),
    .p1_rdata   (p1_rdata),
    .p2_req     (p2_req),
    .p2_cmd     (p2_cmd),
    .p2_addr_ok (p2_addr_ok),
    .p2_data_ok (p2_data_ok),
    .p2_rdata   (p2_rdata),
    .c_req      (c_req),
    .c_cmd      (c_cmd),
    .c_addr_ok  (c_addr_ok),
    .c_data_ok  (c_data_ok),
    .c_rdata    (c_rdata)
  );

  task automatic chk(input string name, input logic [CMD_WD-1:0] act, input logic [CMD_WD-1:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive after the edge, sample at the falling edge.
  // es = expected responding slot (0 or 1), or -1 when no response may appear.
  task automatic cyc(input logic r, input logic q1, input logic q2, input logic aok,
                     input logic dok, input logic [31:0] rd, input int es);
    @(posedge clk);
    #1;
    reset     = r;
    p1_req    = q1;
    p2_req    = q2;
    c_addr_ok = aok;
    c_data_ok = dok;
    c_rdata   = rd;
    if (es >= 0) begin
      exp_slot_q.push_back(es);
      exp_data_q.push_back(rd);
    end
    @(negedge clk);
    chk("data_ok_presence", CMD_WD'(p1_data_ok | p2_data_ok), CMD_WD'(es >= 0));
  endtask

  // Monitor: pop expected response whenever the DUT presents one
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (p1_data_ok || p2_data_ok) begin
        if (exp_slot_q.size() == 0) begin
          n_checks = n_checks + 1;
          n_fail   = n_fail + 1;
          $display("FAIL unexpected_data_ok: p1=%b p2=%b with empty scoreboard at %0t", p1_data_ok, p2_data_ok, $time);
        end else begin
          int          es;
          logic [31:0] ed;
          es = exp_slot_q.pop_front();
          ed = exp_data_q.pop_front();
          chk("resp_slot1", CMD_WD'(p1_data_ok), CMD_WD'(es == 0));
          chk("resp_slot2", CMD_WD'(p2_data_ok), CMD_WD'(es == 1));
          chk("resp_rdata", CMD_WD'(es == 0 ? p1_rdata : p2_rdata), CMD_WD'(ed));
        end
      end
      if (!p1_data_ok) chk("p1_rdata_idle", CMD_WD'(p1_rdata), '0);
      if (!p2_data_ok) chk("p2_rdata_idle", CMD_WD'(p2_rdata), '0);
      if (p1_addr_ok || p2_addr_ok) chk("addr_ok_onehot", CMD_WD'(p1_addr_ok & p2_addr_ok), '0);
    end
  end

  initial begin
    reset = 1'b1; p1_req = 1'b0; p2_req = 1'b0;
    c_addr_ok = 1'b0; c_data_ok = 1'b0; c_rdata = '0;
    p1_cmd = P1CMD; p2_cmd = P2CMD;

    // Reset state
    cyc(1, 1, 1, 1, 0, 32'h0, -1);
    chk("rst_c_req", CMD_WD'(c_req), '0);
    chk("rst_p1_addr_ok", CMD_WD'(p1_addr_ok), '0);
    chk("rst_p2_addr_ok", CMD_WD'(p2_addr_ok), '0);
    cyc(1, 0, 0, 0, 1, 32'h5, -1);
    cyc(0, 0, 0, 0, 0, 32'h0, -1);
    chk("rst_count", CMD_WD'(u_dut.u_id_fifo.count_q), '0);
    chk("rst_err", CMD_WD'(u_dut.err_q), '0);

    // Pair load
    cyc(0, 1, 1, 1, 0, 32'h0, -1);
    chk("pair_p1_addr_ok", CMD_WD'(p1_addr_ok), 1);
    chk("pair_p2_blocked", CMD_WD'(p2_addr_ok), 0);
    chk("pair_cmd1", c_cmd, P1CMD);
    cyc(0, 0, 1, 1, 0, 32'h0, -1);
    chk("pair_p2_addr_ok", CMD_WD'(p2_addr_ok), 1);
    chk("pair_cmd2", c_cmd, P2CMD);
    cyc(0, 0, 0, 0, 1, 32'h1111_1111, 0);
    cyc(0, 0, 0, 0, 1, 32'h2222_2222, 1);
    cyc(0, 0, 0, 0, 0, 32'h0, -1);
    chk("pair_count", CMD_WD'(u_dut.u_id_fifo.count_q), '0);
    chk("idle_cmd_zero", c_cmd, '0);

    // Fill to full: IDs 1,1,2,2
    cyc(0, 1, 0, 1, 0, 32'h0, -1);
    cyc(0, 1, 0, 1, 0, 32'h0, -1);
    cyc(0, 0, 1, 1, 0, 32'h0, -1);
    cyc(0, 0, 1, 1, 0, 32'h0, -1);
    chk("fill_p2_addr_ok", CMD_WD'(p2_addr_ok), 1);
    cyc(0, 1, 0, 1, 0, 32'h0, -1);
    chk("full_c_req", CMD_WD'(c_req), 0);
    chk("full_count", CMD_WD'(u_dut.u_id_fifo.count_q), 4);
    chk("full_no_addr_ok", CMD_WD'(p1_addr_ok), 0);
    cyc(0, 1, 0, 1, 1, 32'hb000_0001, 0);
    chk("full_pop_c_req", CMD_WD'(c_req), 0);
    cyc(0, 1, 0, 1, 0, 32'h0, -1);
    chk("refill_c_req", CMD_WD'(c_req), 1);
    chk("refill_addr_ok", CMD_WD'(p1_addr_ok), 1);
    chk("refill_count", CMD_WD'(u_dut.u_id_fifo.count_q), 3);
    cyc(0, 0, 0, 0, 1, 32'hb000_0002, 0);
    cyc(0, 0, 0, 0, 1, 32'hb000_0003, 1);
    cyc(0, 0, 0, 0, 1, 32'hb000_0004, 1);
    cyc(0, 0, 0, 0, 1, 32'hb000_0005, 0);
    cyc(0, 0, 0, 0, 0, 32'h0, -1);
    chk("drain_count", CMD_WD'(u_dut.u_id_fifo.count_q), '0);

    // Simultaneous push and pop at count 2
    cyc(0, 1, 0, 1, 0, 32'h0, -1);
    cyc(0, 0, 1, 1, 0, 32'h0, -1);
    cyc(0, 1, 0, 1, 1, 32'hc000_0001, 0);
    chk("pp_addr_ok", CMD_WD'(p1_addr_ok), 1);
    chk("pp_count_before", CMD_WD'(u_dut.u_id_fifo.count_q), 2);
    cyc(0, 0, 0, 0, 1, 32'hc000_0002, 1);
    chk("pp_count_after", CMD_WD'(u_dut.u_id_fifo.count_q), 2);
    cyc(0, 0, 0, 0, 1, 32'hc000_0003, 0);

    // Addr_ok stall with both slots requesting
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 0, 32'h0, -1);
      chk("stall_c_req", CMD_WD'(c_req), 1);
      chk("stall_cmd", c_cmd, P1CMD);
      chk("stall_p2_blocked", CMD_WD'(p2_addr_ok), 0);
    end
    cyc(0, 1, 1, 1, 0, 32'h0, -1);
    chk("stall_release_p1", CMD_WD'(p1_addr_ok), 1);
    cyc(0, 0, 1, 1, 0, 32'h0, -1);
    chk("stall_release_p2", CMD_WD'(p2_addr_ok), 1);
    cyc(0, 0, 0, 0, 1, 32'hd000_0001, 0);
    cyc(0, 0, 0, 0, 1, 32'hd000_0002, 1);

    // Reset with three outstanding, then a spurious response
    cyc(0, 1, 0, 1, 0, 32'h0, -1);
    cyc(0, 1, 0, 1, 0, 32'h0, -1);
    cyc(0, 0, 1, 1, 0, 32'h0, -1);
    chk("pre_reset_count", CMD_WD'(u_dut.u_id_fifo.count_q), 2);
    cyc(1, 0, 0, 0, 0, 32'h0, -1);
    cyc(0, 0, 0, 0, 0, 32'h0, -1);
    chk("post_reset_count", CMD_WD'(u_dut.u_id_fifo.count_q), '0);
    chk("post_reset_err", CMD_WD'(u_dut.err_q), '0);
    cyc(0, 0, 0, 0, 1, 32'he000_0001, -1);
    cyc(0, 0, 0, 0, 0, 32'h0, -1);
    chk("spurious_err_set", CMD_WD'(u_dut.err_q), 1);
    chk("spurious_count", CMD_WD'(u_dut.u_id_fifo.count_q), '0);
    cyc(0, 0, 0, 0, 0, 32'h0, -1);
    chk("err_sticky", CMD_WD'(u_dut.err_q), 1);
    cyc(1, 0, 0, 0, 0, 32'h0, -1);
    cyc(0, 0, 0, 0, 0, 32'h0, -1);
    chk("err_cleared", CMD_WD'(u_dut.err_q), '0);

    // Wrap-around: ten back-to-back slot-2 loads, response two cycles after accept
    for (int c = 0; c < 12; c++) begin
      logic [31:0] rdv;
      rdv = 32'ha000_0000 + 32'(c) - 32'd2;
      cyc(0, 0, c < 10, c < 10, c >= 2, rdv, (c >= 2) ? 1 : -1);
      chk("wrap_p2_addr_ok", CMD_WD'(p2_addr_ok), CMD_WD'(c < 10));
      chk("wrap_p1_addr_ok", CMD_WD'(p1_addr_ok), '0);
    end
    cyc(0, 0, 0, 0, 0, 32'h0, -1);
    chk("wrap_wr_ptr", CMD_WD'(u_dut.u_id_fifo.wr_ptr_q), CMD_WD'(10 % DEPTH));
    chk("wrap_rd_ptr", CMD_WD'(u_dut.u_id_fifo.rd_ptr_q), CMD_WD'(10 % DEPTH));
    chk("wrap_count", CMD_WD'(u_dut.u_id_fifo.count_q), '0);

    chk("scoreboard_drained", CMD_WD'(exp_slot_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
